// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle controller (master) and the shared datapath (slave).
// The master drives the memory, register-file, PC and ALU steering strobes.
interface multicycle_control_fsm_if #(
    parameter int unsigned OPCODE_W = 7
);
    logic [OPCODE_W-1:0] opcode;
    logic                alu_bcond;
    logic                mem_ready;
    logic                halt_req;

    logic                mem_read;
    logic                mem_write;
    logic                i_or_d;
    logic                ir_write;
    logic                reg_write;
    logic                mem_to_reg;
    logic                pc_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          alu_op;
    logic                instr_done;
    logic                is_halted;

    modport master (
        input  opcode, alu_bcond, mem_ready, halt_req,
        output mem_read, mem_write, i_or_d, ir_write, reg_write, mem_to_reg, pc_write,
               alu_src_a, alu_src_b, alu_op, instr_done, is_halted
    );

    modport slave (
        output opcode, alu_bcond, mem_ready, halt_req,
        input  mem_read, mem_write, i_or_d, ir_write, reg_write, mem_to_reg, pc_write,
               alu_src_a, alu_src_b, alu_op, instr_done, is_halted
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Control FSM for the multicycle RISC-V core: sequences fetch, decode, execute, memory and
// write-back over a shared ALU and unified memory, stalling on mem_ready and parking on halt.
module multicycle_control_fsm #(
    parameter int unsigned OPCODE_W = 7
) (
    input logic                   clk,
    input logic                   reset,
    multicycle_control_fsm_if.master bus
);

    localparam logic [OPCODE_W-1:0] OpR     = OPCODE_W'(7'b0110011);
    localparam logic [OPCODE_W-1:0] OpI     = OPCODE_W'(7'b0010011);
    localparam logic [OPCODE_W-1:0] OpLoad  = OPCODE_W'(7'b0000011);
    localparam logic [OPCODE_W-1:0] OpStore = OPCODE_W'(7'b0100011);
    localparam logic [OPCODE_W-1:0] OpBr    = OPCODE_W'(7'b1100011);
    localparam logic [OPCODE_W-1:0] OpJal   = OPCODE_W'(7'b1101111);
    localparam logic [OPCODE_W-1:0] OpJalr  = OPCODE_W'(7'b1100111);
    localparam logic [OPCODE_W-1:0] OpSys   = OPCODE_W'(7'b1110011);

    localparam logic [1:0] SrcBReg  = 2'b00;
    localparam logic [1:0] SrcBFour = 2'b01;
    localparam logic [1:0] SrcBImm  = 2'b10;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluBr    = 2'b01;
    localparam logic [1:0] AluRFn   = 2'b10;
    localparam logic [1:0] AluIFn   = 2'b11;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StExR,
        StExI,
        StExAddr,
        StMemRd,
        StMemWr,
        StWbAlu,
        StWbMem,
        StBrEx,
        StBrPc,
        StJmpLink,
        StJalPc,
        StJalrPc,
        StHalt
    } state_e;

    state_e state_q;
    logic   taken_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            taken_q <= 1'b0;
        end else begin
            case (state_q)
                StFetch: begin
                    if (bus.mem_ready) state_q <= StDecode;
                end
                StDecode: begin
                    if (bus.opcode == OpR) begin
                        state_q <= StExR;
                    end else if (bus.opcode == OpI) begin
                        state_q <= StExI;
                    end else if (bus.opcode == OpLoad || bus.opcode == OpStore) begin
                        state_q <= StExAddr;
                    end else if (bus.opcode == OpBr) begin
                        state_q <= StBrEx;
                    end else if (bus.opcode == OpJal || bus.opcode == OpJalr) begin
                        state_q <= StJmpLink;
                    end else if (bus.opcode == OpSys && bus.halt_req) begin
                        state_q <= StHalt;
                    end else begin
                        state_q <= StFetch;
                    end
                end
                StExR, StExI: state_q <= StWbAlu;
                StExAddr: state_q <= (bus.opcode == OpLoad) ? StMemRd : StMemWr;
                StMemRd: begin
                    if (bus.mem_ready) state_q <= StWbMem;
                end
                StMemWr: begin
                    if (bus.mem_ready) state_q <= StFetch;
                end
                StWbAlu, StWbMem: state_q <= StFetch;
                StBrEx: begin
                    taken_q <= bus.alu_bcond;
                    state_q <= StBrPc;
                end
                StBrPc: state_q <= StFetch;
                StJmpLink: state_q <= (bus.opcode == OpJal) ? StJalPc : StJalrPc;
                StJalPc, StJalrPc: state_q <= StFetch;
                StHalt: state_q <= StHalt;
                default: state_q <= StFetch;
            endcase
        end
    end

    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       is_halted;
    logic       decode_fallthru;

    // Anything ID does not dispatch (including a non-halting ecall) just steps PC by 4.
    always_comb begin
        decode_fallthru = !(bus.opcode == OpR || bus.opcode == OpI || bus.opcode == OpLoad ||
                            bus.opcode == OpStore || bus.opcode == OpBr || bus.opcode == OpJal ||
                            bus.opcode == OpJalr || (bus.opcode == OpSys && bus.halt_req));
    end

    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        pc_write   = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SrcBReg;
        alu_op     = AluAdd;
        instr_done = 1'b0;
        is_halted  = 1'b0;
        if (!reset) begin
            case (state_q)
                StFetch: begin
                    mem_read = 1'b1;
                    ir_write = bus.mem_ready;
                end
                StDecode: begin
                    if (decode_fallthru) begin
                        alu_src_b  = SrcBFour;
                        pc_write   = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                StExR: begin
                    alu_src_a = 1'b1;
                    alu_op    = AluRFn;
                end
                StExI: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SrcBImm;
                    alu_op    = AluIFn;
                end
                StExAddr: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SrcBImm;
                end
                StMemRd: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                StMemWr: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    if (bus.mem_ready) begin
                        alu_src_b  = SrcBFour;
                        pc_write   = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                StWbAlu, StWbMem: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (state_q == StWbMem);
                    alu_src_b  = SrcBFour;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
                StBrEx: begin
                    alu_src_a = 1'b1;
                    alu_op    = AluBr;
                end
                StBrPc: begin
                    alu_src_b  = taken_q ? SrcBImm : SrcBFour;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
                StJmpLink: begin
                    alu_src_b = SrcBFour;
                end
                StJalPc, StJalrPc: begin
                    reg_write  = 1'b1;
                    alu_src_a  = (state_q == StJalrPc);
                    alu_src_b  = SrcBImm;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
                StHalt: begin
                    is_halted = 1'b1;
                end
                default: begin
                    is_halted = 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.i_or_d     = i_or_d;
    assign bus.ir_write   = ir_write;
    assign bus.reg_write  = reg_write;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.pc_write   = pc_write;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_op     = alu_op;
    assign bus.instr_done = instr_done;
    assign bus.is_halted  = is_halted;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class cycle by cycle and
// compares the full control word against hand-written expectations.
module tb_multicycle_control_fsm;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    multicycle_control_fsm_if #(.OPCODE_W(7)) bus ();

    multicycle_control_fsm #(.OPCODE_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Control word: {mr, mw, iod, irw, rw, m2r, pcw, a, b[1:0], op[1:0], done, halt}
    localparam logic [13:0] MR    = 14'h2000;
    localparam logic [13:0] MW    = 14'h1000;
    localparam logic [13:0] IOD   = 14'h0800;
    localparam logic [13:0] IRW   = 14'h0400;
    localparam logic [13:0] RW    = 14'h0200;
    localparam logic [13:0] M2R   = 14'h0100;
    localparam logic [13:0] PCW   = 14'h0080;
    localparam logic [13:0] SA    = 14'h0040;
    localparam logic [13:0] B_4   = 14'h0010;
    localparam logic [13:0] B_IMM = 14'h0020;
    localparam logic [13:0] OP_BR = 14'h0004;
    localparam logic [13:0] OP_R  = 14'h0008;
    localparam logic [13:0] OP_I  = 14'h000C;
    localparam logic [13:0] DONE  = 14'h0002;
    localparam logic [13:0] HALT  = 14'h0001;
    localparam logic [13:0] NONE  = 14'h0000;

    localparam logic [6:0] R_ADD = 7'b0110011;
    localparam logic [6:0] I_ADD = 7'b0010011;
    localparam logic [6:0] LW    = 7'b0000011;
    localparam logic [6:0] SW    = 7'b0100011;
    localparam logic [6:0] BEQ   = 7'b1100011;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] ECALL = 7'b1110011;
    localparam logic [6:0] LUI   = 7'b0110111;

    logic [13:0] outs;
    assign outs = {bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write, bus.reg_write,
                   bus.mem_to_reg, bus.pc_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                   bus.instr_done, bus.is_halted};

    // Check the current cycle's outputs just after inputs settle, then advance one cycle.
    task automatic cyc(input string tag, input logic [13:0] exp);
        #1;
        checks++;
        assert (outs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, outs, exp);
        end
        @(negedge clk);
    endtask

    initial begin
        reset         = 1'b1;
        bus.opcode    = '0;
        bus.alu_bcond = 1'b0;
        bus.mem_ready = 1'b1;
        bus.halt_req  = 1'b0;
        @(negedge clk);
        cyc("reset0", NONE);
        cyc("reset1", NONE);
        reset = 1'b0;

        bus.opcode = R_ADD;
        cyc("add_if", MR | IRW);
        cyc("add_id", NONE);
        cyc("add_ex", SA | OP_R);
        cyc("add_wb", RW | PCW | B_4 | DONE);

        bus.opcode = I_ADD;
        cyc("addi_if", MR | IRW);
        cyc("addi_id", NONE);
        cyc("addi_ex", SA | B_IMM | OP_I);
        cyc("addi_wb", RW | PCW | B_4 | DONE);

        bus.opcode = LW;
        cyc("lw_if", MR | IRW);
        cyc("lw_id", NONE);
        cyc("lw_ex", SA | B_IMM);
        bus.mem_ready = 1'b0;
        cyc("lw_wait0", MR | IOD);
        cyc("lw_wait1", MR | IOD);
        bus.mem_ready = 1'b1;
        cyc("lw_mem", MR | IOD);
        cyc("lw_wb", RW | M2R | PCW | B_4 | DONE);

        bus.opcode = BEQ;
        bus.alu_bcond = 1'b1;
        cyc("beq_t_if", MR | IRW);
        cyc("beq_t_id", NONE);
        cyc("beq_t_ex", SA | OP_BR);
        bus.alu_bcond = 1'b0;
        cyc("beq_t_pc", PCW | B_IMM | DONE);
        cyc("beq_n_if", MR | IRW);
        cyc("beq_n_id", NONE);
        cyc("beq_n_ex", SA | OP_BR);
        bus.alu_bcond = 1'b1;
        cyc("beq_n_pc", PCW | B_4 | DONE);

        bus.opcode = JAL;
        cyc("jal_if", MR | IRW);
        cyc("jal_id", NONE);
        cyc("jal_link", B_4);
        cyc("jal_pc", RW | PCW | B_IMM | DONE);
        bus.opcode = JALR;
        cyc("jalr_if", MR | IRW);
        cyc("jalr_id", NONE);
        cyc("jalr_link", B_4);
        cyc("jalr_pc", RW | PCW | SA | B_IMM | DONE);

        bus.opcode = SW;
        cyc("sw_if", MR | IRW);
        cyc("sw_id", NONE);
        cyc("sw_ex", SA | B_IMM);
        bus.mem_ready = 1'b0;
        cyc("sw_wait", MW | IOD);
        bus.mem_ready = 1'b1;
        cyc("sw_mem", MW | IOD | PCW | B_4 | DONE);

        bus.opcode = LUI;
        cyc("unk_if", MR | IRW);
        cyc("unk_id", PCW | B_4 | DONE);

        bus.opcode = ECALL;
        bus.halt_req = 1'b0;
        cyc("ecall_if", MR | IRW);
        cyc("ecall_id", PCW | B_4 | DONE);
        bus.mem_ready = 1'b0;
        cyc("ecall_back_if", MR);
        bus.mem_ready = 1'b1;

        bus.halt_req = 1'b1;
        cyc("halt_if", MR | IRW);
        cyc("halt_id", NONE);
        for (int i = 0; i < 20; i++) begin
            bus.opcode    = 7'($urandom);
            bus.alu_bcond = 1'($urandom);
            bus.mem_ready = 1'($urandom);
            bus.halt_req  = 1'($urandom);
            cyc("halted", HALT);
        end

        bus.halt_req  = 1'b0;
        bus.mem_ready = 1'b1;
        reset = 1'b1;
        cyc("reset_from_halt", NONE);
        reset = 1'b0;

        bus.opcode = SW;
        cyc("sw2_if", MR | IRW);
        cyc("sw2_id", NONE);
        cyc("sw2_ex", SA | B_IMM);
        bus.mem_ready = 1'b0;
        cyc("sw2_wait", MW | IOD);
        reset = 1'b1;
        cyc("reset_in_memwr", NONE);
        reset = 1'b0;
        cyc("post_reset_if", MR);
        bus.mem_ready = 1'b1;
        cyc("post_reset_if_ready", MR | IRW);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
